// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - redirect, ROM read and instruction handshake bundle for instr_fetch
interface instr_fetch_if #(
  parameter int PC_W = 16
);

  // redirect from control
  logic            pcLoad;
  logic [PC_W-1:0] pcLoadAddr;

  // program ROM port (16-bit words, 1-cycle read latency)
  logic [PC_W:0]   romAddr;
  logic            romRead;
  logic [15:0]     romData;

  // assembled instruction towards control
  logic [31:0]     controlWord;
  logic [PC_W-1:0] cwPc;
  logic            cwValid;
  logic            cwReady;

  // fetch stage side
  modport master (
    input  pcLoad, pcLoadAddr, romData, cwReady,
    output romAddr, romRead, controlWord, cwPc, cwValid
  );

  // environment side: control unit plus program ROM
  modport slave (
    output pcLoad, pcLoadAddr, romData, cwReady,
    input  romAddr, romRead, controlWord, cwPc, cwValid
  );

endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - two-word ROM fetch, 32-bit instruction assembly and instruction queue
module instr_fetch #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RST,
  instr_fetch_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ISSUE_LO,
    ISSUE_HI,
    CAPTURE
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] next_pc;
  logic [15:0]     lo_q, lo_d;
  logic [PC_W:0]   rom_addr_q, rom_addr_d;
  logic [PC_W:0]   addr_c;
  logic            rd_c;
  logic            push;
  logic            pop;

  logic [31:0]     cw_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic            full;
  logic            room_for_next;

  assign full          = (count_q == FULL_CNT);
  // In CAPTURE the instruction being pushed already holds a slot, so a
  // further read may only start if one more slot stays free after the push.
  assign room_for_next = (count_q < LAST_FREE);
  assign next_pc       = fetch_pc_q + PC_W'(1);

  // Fetch FSM next state, ROM request and instruction assembly
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    lo_d       = lo_q;
    rd_c       = 1'b0;
    addr_c     = rom_addr_q;
    push       = 1'b0;

    case (state_q)
      ISSUE_LO: begin
        // pending is zero here, so free space is simply "not full"
        if (!full) begin
          rd_c    = 1'b1;
          addr_c  = {fetch_pc_q, 1'b0};
          state_d = ISSUE_HI;
        end
      end
      ISSUE_HI: begin
        rd_c    = 1'b1;
        addr_c  = {fetch_pc_q, 1'b1};
        lo_d    = bus.romData;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        push       = 1'b1;
        fetch_pc_d = next_pc;
        // overlap the next low-word read with this capture when room allows
        if (room_for_next) begin
          rd_c    = 1'b1;
          addr_c  = {next_pc, 1'b0};
          state_d = ISSUE_HI;
        end else begin
          state_d = ISSUE_LO;
        end
      end
      default: begin
        state_d = ISSUE_LO;
      end
    endcase

    // A redirect overrides everything: drop the in-flight instruction and
    // restart at the target; data returning next cycle is ignored by ISSUE_LO.
    if (bus.pcLoad) begin
      state_d    = ISSUE_LO;
      fetch_pc_d = bus.pcLoadAddr;
      push       = 1'b0;
    end
  end

  // ROM address is held at its last issued value while no read is made
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (rd_c) begin
      rom_addr_d = addr_c;
    end
  end

  assign bus.romRead = rd_c & ~RST;
  assign bus.romAddr = bus.romRead ? addr_c : rom_addr_q;

  // Fetch FSM and ROM-side registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ISSUE_LO;
      fetch_pc_q <= '0;
      lo_q       <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      lo_q       <= lo_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign pop = bus.cwValid & bus.cwReady;

  // Queue pointer and occupancy update; a redirect flushes and voids any pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.pcLoad) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage; the high word is taken straight from the ROM in CAPTURE
  always_ff @(posedge CLK) begin
    if (push) begin
      cw_mem_q[tail_q] <= {bus.romData, lo_q};
      pc_mem_q[tail_q] <= fetch_pc_q;
    end
  end

  // Head entry is masked to zero while empty so flushed entries never show
  assign bus.cwValid     = (count_q != '0);
  assign bus.controlWord = bus.cwValid ? cw_mem_q[head_q] : '0;
  assign bus.cwPc        = bus.cwValid ? pc_mem_q[head_q] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch with a stream-level reference model
module tb_instr_fetch;

  localparam int PC_W  = 16;
  localparam int DEPTH = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  instr_fetch_if #(.PC_W(PC_W)) bus ();

  instr_fetch #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] salt;

  // model state: next pc the consumer must see, cycles since last restart
  logic [PC_W-1:0] exp_pc;
  int              idx;
  bit              last_rst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // program ROM contents: fixed first two words, hashed elsewhere
  function automatic logic [15:0] rom_word(input logic [PC_W:0] a);
    logic [31:0] h;
    if (a == 0) return 16'h2A06;
    if (a == 1) return 16'h1234;
    h = ({15'd0, a} * 32'h9E3779B1) ^ salt;
    return h[31:16] ^ h[15:0];
  endfunction

  function automatic logic [31:0] cw_of(input logic [PC_W-1:0] pc);
    return {rom_word({pc, 1'b1}), rom_word({pc, 1'b0})};
  endfunction

  // synchronous ROM, garbage on the bus when not read
  always @(posedge CLK) begin
    bus.romData <= bus.romRead ? rom_word(bus.romAddr) : 16'($urandom);
  end

  // one clock cycle: inputs already set, check outputs, advance model at the edge
  task automatic step();
    logic fire;
    #1;
    if (RST) check("rd_in_rst", bus.romRead, 0);
    if (last_rst) begin
      check("rst_valid", bus.cwValid, 0);
      check("rst_cw", bus.controlWord, 0);
      check("rst_pc", bus.cwPc, 0);
      check("rst_addr", bus.romAddr, 0);
    end
    if (idx < 3) check("lat_gap", bus.cwValid, 0);
    if (idx == 3) check("lat_first", bus.cwValid, 1);
    if (!RST && !bus.pcLoad && idx == 0) begin
      check("lo_rd", bus.romRead, 1);
      check("lo_addr", bus.romAddr, {exp_pc, 1'b0});
    end
    if (!RST && !bus.pcLoad && idx == 1) begin
      check("hi_rd", bus.romRead, 1);
      check("hi_addr", bus.romAddr, {exp_pc, 1'b1});
    end
    if (bus.cwValid) begin
      check("cw_pc", bus.cwPc, exp_pc);
      check("cw_data", bus.controlWord, cw_of(exp_pc));
    end
    check("push_full", (dut.push && dut.count_q == DEPTH), 0);
    fire = bus.cwValid & bus.cwReady & ~bus.pcLoad & ~RST;
    @(posedge CLK);
    if (RST) begin
      exp_pc   = '0;
      idx      = 0;
      last_rst = 1'b1;
    end else if (bus.pcLoad) begin
      exp_pc   = bus.pcLoadAddr;
      idx      = 0;
      last_rst = 1'b0;
    end else begin
      if (fire) exp_pc = exp_pc + 1'b1;
      idx      = idx + 1;
      last_rst = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic redirect(input logic [PC_W-1:0] a);
    bus.pcLoad     = 1'b1;
    bus.pcLoadAddr = a;
    step();
    bus.pcLoad     = 1'b0;
  endtask

  initial begin
    salt           = $urandom;
    RST            = 1'b1;
    bus.pcLoad     = 1'b0;
    bus.pcLoadAddr = '0;
    bus.cwReady    = 1'b1;
    exp_pc         = '0;
    idx            = 0;
    last_rst       = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    last_rst = 1'b1;
    step();

    // first instruction after reset, then in-order stream
    RST = 1'b0;
    repeat (3) step();
    #1;
    check("tp1_cw", bus.controlWord, 32'h12342A06);
    check("tp1_pc", bus.cwPc, 0);
    repeat (8) step();

    // consumer stalled: queue fills to DEPTH and reads stop
    RST = 1'b1;
    bus.cwReady = 1'b0;
    repeat (2) step();
    RST = 1'b0;
    repeat (10) step();
    #1;
    check("stall_rd", bus.romRead, 0);
    check("stall_v", bus.cwValid, 1);
    bus.cwReady = 1'b1;
    step();
    #1;
    check("stall_v1", bus.cwValid, 1);
    check("stall_pc1", bus.cwPc, 1);
    repeat (8) step();

    // redirect with an entry queued and a fetch in flight
    bus.cwReady = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    repeat (4) step();
    redirect(16'h0040);
    #1;
    check("tp3_v0", bus.cwValid, 0);
    repeat (3) step();
    #1;
    check("tp3_pc", bus.cwPc, 16'h0040);
    check("tp3_cw", bus.controlWord, cw_of(16'h0040));
    bus.cwReady = 1'b1;
    repeat (8) step();

    // redirect on a pop edge, then a second redirect one cycle later
    for (int i = 0; i < 4 && !bus.cwValid; i++) step();
    redirect(16'h0200);
    redirect(16'h0100);
    repeat (3) step();
    #1;
    check("tp4_pc", bus.cwPc, 16'h0100);
    repeat (6) step();

    // pc wrap from 0xFFFF to 0
    redirect(16'hFFFF);
    #1;
    check("tp5_lo", bus.romAddr, 17'h1FFFE);
    step();
    #1;
    check("tp5_hi", bus.romAddr, 17'h1FFFF);
    repeat (2) step();
    #1;
    check("tp5_pc", bus.cwPc, 16'hFFFF);
    step();
    for (int i = 0; i < 6 && !(bus.cwValid && bus.cwPc != 16'hFFFF); i++) step();
    #1;
    check("tp5_wrap", bus.cwPc, 0);
    repeat (4) step();

    // reset mid-fetch with one entry queued
    bus.cwReady = 1'b0;
    redirect(16'h0300);
    repeat (4) step();
    RST = 1'b1;
    step();
    #1;
    check("tp6_v", bus.cwValid, 0);
    check("tp6_rd", bus.romRead, 0);
    step();
    RST = 1'b0;
    bus.cwReady = 1'b1;
    repeat (3) step();
    #1;
    check("tp6_v3", bus.cwValid, 1);
    check("tp6_pc0", bus.cwPc, 0);
    repeat (6) step();

    // randomized traffic: stalls, redirects near and far, occasional reset
    repeat (2500) begin
      bus.cwReady = ($urandom_range(0, 3) != 0);
      bus.pcLoad  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.pcLoadAddr = 16'hFFFF - 16'($urandom_range(0, 2));
      else
        bus.pcLoadAddr = 16'($urandom);
      RST = ($urandom_range(0, 149) == 0);
      step();
    end
    RST = 1'b0;
    bus.pcLoad = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
